// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C target with a DEPTH x 8 register memory.
// SCL/SDA are oversampled on clk; SDA is driven open-drain.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   scl, sda_i    bus SCL and sampled SDA (asynchronous)
//   sda_oe        1 = pull SDA low, 0 = release
//   busy          addressed by a matching START until STOP/mismatch
//   wr_stb        one-cycle pulse per data byte written to memory
//   wr_addr       memory address of that write
//   wr_data       data byte of that write
module i2c_slave_mem #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter int         DEPTH    = 64,
  parameter int         AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

  state_t        state;
  logic [2:0]    scl_q;
  logic [2:0]    sda_q;
  logic [6:0]    sr;
  logic [6:0]    tx;
  logic [3:0]    cnt;
  logic          rw;
  logic          ack_phase;
  logic [AW-1:0] ptr;
  logic [7:0]    mem [DEPTH];

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] byte_in;

  // Stages [1:0] synchronise, stage [2] is the previous value.
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & ~sda_q[2] & sda_q[1];
  assign byte_in   = {sr, sda_q[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronisers reset to the idle-high bus level so no
      // spurious START/STOP is seen coming out of reset.
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      state     <= IDLE;
      sr        <= '0;
      tx        <= '0;
      cnt       <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      scl_q  <= {scl_q[1:0], scl};
      sda_q  <= {sda_q[1:0], sda_i};
      wr_stb <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        cnt       <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        cnt       <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            sda_oe <= 1'b0;
          end
          ADDR: begin
            if (scl_rise) begin
              sr  <= byte_in[6:0];
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  busy  <= 1'b1;
                  rw    <= byte_in[0];
                  state <= ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK: begin
            // First fall opens the ACK, second fall closes it.
            if (scl_fall) begin
              if (!ack_phase) begin
                ack_phase <= 1'b1;
                sda_oe    <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                cnt       <= '0;
                if (rw) begin
                  state  <= RDATA;
                  tx     <= mem[ptr][6:0];
                  sda_oe <= ~mem[ptr][7];
                end else begin
                  state  <= PTR;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          PTR: begin
            if (scl_rise) begin
              sr  <= byte_in[6:0];
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                ptr   <= byte_in[AW-1:0];
                state <= PTR_ACK;
              end
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                ack_phase <= 1'b1;
                sda_oe    <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                cnt       <= '0;
                sda_oe    <= 1'b0;
                state     <= WDATA;
              end
            end
          end
          WDATA: begin
            if (scl_rise) begin
              sr  <= byte_in[6:0];
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                mem[ptr] <= byte_in;
                wr_stb   <= 1'b1;
                wr_addr  <= ptr;
                wr_data  <= byte_in;
                ptr      <= ptr + AW'(1);
                state    <= WDATA_ACK;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + AW'(1);
                state  <= RDATA_ACK;
              end else begin
                sda_oe <= ~tx[6];
                tx     <= {tx[5:0], 1'b0};
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_q[1]) state <= IGNORE;
              else ack_phase <= 1'b1;
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              cnt       <= '0;
              tx        <= mem[ptr][6:0];
              sda_oe    <= ~mem[ptr][7];
              state     <= RDATA;
            end
          end
          IGNORE: begin
            sda_oe <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb_i2c_slave_mem: bus-level bench for i2c_slave_mem.
// Two targets share the bus: default (0x68, 64 B) and 0x50 / 16 B.
module tb_i2c_slave_mem;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;

  logic       oe_a;
  logic       busy_a;
  logic       stb_a;
  logic [5:0] addr_a;
  logic [7:0] data_a;
  logic       oe_b;
  logic       busy_b;
  logic       stb_b;
  logic [3:0] addr_b;
  logic [7:0] data_b;

  wire sda_bus = m_sda & ~oe_a & ~oe_b;

  i2c_slave_mem dut_a (
    .clk(clk), .rst(rst), .scl(scl), .sda_i(sda_bus),
    .sda_oe(oe_a), .busy(busy_a), .wr_stb(stb_a),
    .wr_addr(addr_a), .wr_data(data_a)
  );

  i2c_slave_mem #(.DEV_ADDR(7'h50), .DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .scl(scl), .sda_i(sda_bus),
    .sda_oe(oe_b), .busy(busy_b), .wr_stb(stb_b),
    .wr_addr(addr_b), .wr_data(data_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int stb_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  int stb_b_cnt = 0;
  logic [5:0] wq_addr[$];
  logic [7:0] wq_data[$];

  always @(posedge clk) begin
    if (stb_a) begin
      stb_cnt++;
      wq_addr.push_back(addr_a);
      wq_data.push_back(data_a);
    end
    if (oe_a) oe_cnt++;
    if (busy_a) busy_cnt++;
    if (stb_b) stb_b_cnt++;
  end

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
    logic [5:0] exp_addr;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic r);
    tick(Q); m_sda = b;
    tick(Q); scl = 1'b1;
    tick(Q); r = sda_bus;
    tick(Q); scl = 1'b0;
  endtask

  task automatic i2c_start;
    tick(Q); m_sda = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); m_sda = 1'b0;
    tick(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop;
    tick(Q); m_sda = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); m_sda = 1'b1;
    tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, r);
    ack = ~r;
  endtask

  task automatic rbyte(input logic ack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_x(1'b1, r);
      d = {d[6:0], r};
    end
    bit_x(~ack, r);
  endtask

  task automatic read1(input logic [7:0] dw, input logic [7:0] p,
                       output logic [7:0] d);
    logic a;
    i2c_start;
    wbyte(dw, a);
    wbyte(p, a);
    i2c_start;
    wbyte(dw | 8'h01, a);
    rbyte(1'b0, d);
    i2c_stop;
  endtask

  initial begin
    logic       a;
    logic       r;
    logic [7:0] d;
    logic [7:0] e;
    int         n0;
    int         o0;
    int         b0;

    tbl[0] = '{8'hD0, 8'h10, 8'h5A, 1'b1, 6'h10, 8'h5A};
    tbl[1] = '{8'hD0, 8'h9F, 8'hC3, 1'b1, 6'h1F, 8'hC3};
    tbl[2] = '{8'hD2, 8'h10, 8'hFF, 1'b0, 6'h00, 8'h5A};
    tbl[3] = '{8'hD0, 8'h20, 8'h00, 1'b1, 6'h20, 8'h00};
    tbl[4] = '{8'hD0, 8'h3E, 8'h81, 1'b1, 6'h3E, 8'h81};
    tbl[5] = '{8'hD8, 8'h3E, 8'h7E, 1'b0, 6'h00, 8'h81};

    tick(4);
    rst = 1'b0;
    tick(2);
    chk("rst_oe", oe_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_stb", stb_a, 1'b0);
    chk("rst_addr", addr_a, 6'h00);
    chk("rst_data", data_a, 8'h00);

    // Write 05: A5, 3C
    n0 = wq_addr.size();
    i2c_start;
    wbyte(8'hD0, a); chk("wr_dev_ack", a, 1'b1);
    wbyte(8'h05, a); chk("wr_ptr_ack", a, 1'b1);
    wbyte(8'hA5, a); chk("wr_d0_ack", a, 1'b1);
    wbyte(8'h3C, a); chk("wr_d1_ack", a, 1'b1);
    chk("wr_busy", busy_a, 1'b1);
    i2c_stop;
    chk("wr_stb_cnt", wq_addr.size() - n0, 2);
    if (wq_addr.size() - n0 == 2) begin
      chk("wr_addr0", wq_addr[n0], 6'h05);
      chk("wr_data0", wq_data[n0], 8'hA5);
      chk("wr_addr1", wq_addr[n0+1], 6'h06);
      chk("wr_data1", wq_data[n0+1], 8'h3C);
    end
    chk("wr_busy_stop", busy_a, 1'b0);

    // Random read with repeated START
    i2c_start;
    wbyte(8'hD0, a);
    wbyte(8'h05, a);
    i2c_start;
    wbyte(8'hD1, a); chk("rd_dev_ack", a, 1'b1);
    rbyte(1'b1, d); chk("rd_b0", d, 8'hA5);
    rbyte(1'b0, d); chk("rd_b1", d, 8'h3C);
    i2c_stop;
    chk("rd_busy_stop", busy_a, 1'b0);

    // Pointer wrap
    n0 = wq_addr.size();
    i2c_start;
    wbyte(8'hD0, a);
    wbyte(8'h3F, a);
    wbyte(8'h11, a);
    wbyte(8'h22, a);
    i2c_stop;
    chk("wrap_stb_cnt", wq_addr.size() - n0, 2);
    if (wq_addr.size() - n0 == 2) begin
      chk("wrap_addr0", wq_addr[n0], 6'h3F);
      chk("wrap_addr1", wq_addr[n0+1], 6'h00);
    end
    i2c_start;
    wbyte(8'hD0, a);
    wbyte(8'h3F, a);
    i2c_start;
    wbyte(8'hD1, a);
    rbyte(1'b1, d); chk("wrap_rd63", d, 8'h11);
    rbyte(1'b0, d); chk("wrap_rd0", d, 8'h22);
    i2c_stop;
    read1(8'hD0, 8'h45, d); chk("ptr_45_to_5", d, 8'hA5);

    // Address mismatch (0x50 belongs to the other target)
    n0 = stb_cnt;
    o0 = oe_cnt;
    b0 = busy_cnt;
    i2c_start;
    wbyte(8'hA0, a);
    wbyte(8'hFF, a);
    i2c_stop;
    chk("mm_oe_cycles", oe_cnt - o0, 0);
    chk("mm_stb", stb_cnt - n0, 0);
    chk("mm_busy_cycles", busy_cnt - b0, 0);
    read1(8'hD0, 8'h05, d); chk("mm_mem5", d, 8'hA5);

    // Table vectors: write one byte, read it back
    foreach (tbl[k]) begin
      n0 = stb_cnt;
      i2c_start;
      wbyte(tbl[k].dev, a);
      chk($sformatf("vec%0d_ack", k), a, tbl[k].exp_ack);
      wbyte(tbl[k].ptr, r);
      wbyte(tbl[k].data, r);
      i2c_stop;
      chk($sformatf("vec%0d_stb", k), stb_cnt - n0, tbl[k].exp_ack);
      if (tbl[k].exp_ack) begin
        chk($sformatf("vec%0d_waddr", k), addr_a, tbl[k].exp_addr);
        chk($sformatf("vec%0d_wdata", k), data_a, tbl[k].data);
      end
      read1(8'hD0, tbl[k].ptr, d);
      chk($sformatf("vec%0d_rd", k), d, tbl[k].exp_rd);
    end

    // Reset during bit 4 of a read of mem[5] = A5 (bit is 0)
    i2c_start;
    wbyte(8'hD0, a);
    wbyte(8'h05, a);
    i2c_start;
    wbyte(8'hD1, a);
    for (int i = 0; i < 3; i++) bit_x(1'b1, r);
    tick(Q); m_sda = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q);
    chk("rstrd_oe_before", oe_a, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstrd_oe", oe_a, 1'b0);
    chk("rstrd_busy", busy_a, 1'b0);
    chk("rstrd_stb", stb_a, 1'b0);
    chk("rstrd_addr", addr_a, 6'h00);
    chk("rstrd_data", data_a, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(Q);
    read1(8'hD0, 8'h05, d); chk("rstrd_mem5", d, 8'h00);
    read1(8'hD0, 8'h3F, d); chk("rstrd_mem63", d, 8'h00);
    i2c_start;
    wbyte(8'hD0, a); chk("rstrd_w_ack", a, 1'b1);
    wbyte(8'h05, a);
    wbyte(8'h77, a);
    i2c_stop;
    read1(8'hD0, 8'h05, d); chk("rstrd_rd", d, 8'h77);

    // DEPTH=16 / 0x50 sweep
    n0 = stb_b_cnt;
    i2c_start;
    wbyte(8'hA0, a); chk("sw_dev_ack", a, 1'b1);
    wbyte(8'h00, a);
    for (int i = 0; i < 16; i++) begin
      e = ~8'(i);
      wbyte(e, a);
    end
    i2c_stop;
    chk("sw_stb_cnt", stb_b_cnt - n0, 16);
    i2c_start;
    wbyte(8'hA0, a);
    wbyte(8'h00, a);
    i2c_start;
    wbyte(8'hA1, a);
    for (int i = 0; i < 16; i++) begin
      e = ~8'(i);
      rbyte(i != 15, d);
      chk($sformatf("sw_rd%0d", i), d, e);
    end
    i2c_stop;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
